lsp_prev_update: RTL
====================

# lsp_prev_update

Updates the G.729 LSP quantizer's moving-average predictor history after each frame. It shifts the four-deep `freq_prev` history in scratch memory by one frame: rows 0..2 move to rows 1..3, and row 0 is overwritten with the current frame's `lsp_ele` vector. It sits directly downstream of `Lsp_prev_extract` in the Qua_Lsp path and uses the same shared-scratch-memory read/write port convention. The next frame's extract/quantize stages consume the updated history.

## Interface
Parameters:
- `M`, 10, LSP order; elements per history row.
- `MA_NP`, 4, MA predictor depth; number of history rows.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `lspele`  in  11  base address of the `lsp_ele` vector. Element j lives at {lspele[10:4], j[3:0]}.
- `freq_prev`  in  11  base address of the history. Element [k][j] lives at {freq_prev[10:6], (10k+j)[5:0]}.
- `readIn`  in  32  scratch-memory read data.
- `readAddr`  out  11  scratch-memory read address.
- `writeAddr`  out  11  scratch-memory write address.
- `writeOut`  out  32  scratch-memory write data.
- `writeEn`  out  1  write strobe; memory writes on a rising edge where it is 1.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Memory model: synchronous read. `readIn` reflects the `readAddr` registered at the previous rising edge.
- Copy sequence, 40 word moves, strictly in this order:
  - k = 3, 2, 1; for each k, j = 0..9: dst [k][j] ← src [k−1][j].
  - Then j = 0..9: dst [0][j] ← `lsp_ele[j]`.
  - Descending k guarantees each source is read before it is overwritten.
- Data rule: `writeOut` = {{16{readIn[15]}}, readIn[15:0]}, i.e. the 16-bit Q13 value sign-extended. Upper input bits are ignored.
- FSM states:
  - IDLE: wait for `start`.
  - RD: drive `readAddr` = source address.
  - WAIT: memory latency cycle; `readAddr` held.
  - WR: `writeAddr` = destination address, `writeOut` = formatted `readIn` captured in this cycle, `writeEn` = 1. Then advance the index and go to RD, or to DONE after the 40th word.
  - DONE: `done` = 1; return to IDLE.
- Counters: row counter k (2 bits) and element counter j (4 bits). j wraps 9→0 and decrements k; after k=1 a phase flag selects the `lsp_ele` source. A separate word counter 0..39 is acceptable.
- Address arithmetic: the 6-bit offset 10k+j is computed combinationally (max 39, no overflow). Base high bits are concatenated, not added.
- `start` while not in IDLE is ignored. `start` held high through DONE does not cause a retrigger until IDLE samples it again.
- Base inputs `lspele`/`freq_prev` must be stable from `start` until `done`. The block does not register them.

## Timing
- Reset values: `done` = 0, `writeEn` = 0, `readAddr` = 0, `writeAddr` = 0, `writeOut` = 0; FSM in IDLE; counters = 0.
- Reset asserted mid-operation: immediately return to IDLE with the reset values above; `writeEn` drops asynchronously. Memory is left partially updated. No `done` is issued for the aborted run.
- Latency: `start` sampled at edge T0 → RD at cycle 1 → 3 cycles per word → DONE at cycle 121 (`done` high for exactly one cycle) → IDLE at cycle 122.
- A new `start` is accepted in the IDLE cycle following DONE. The back-to-back period is 122 cycles.
- `writeEn` is high in exactly 40 cycles per run, never in consecutive cycles.
- `readAddr` and `writeAddr` are registered outputs. `writeEn` is never 1 outside WR.

## Test plan
- Basic shift:
  - Preload: `freq_prev`[k][j] = 16'h1000·(k+1) + j; `lsp_ele[j]` = 16'h0A00 + j; bases `lspele` = 288, `freq_prev` = 320.
  - Pulse `start`.
  - Required after `done`: row3 = 16'h3000+j, row2 = 16'h2000+j, row1 = 16'h1000+j, row0 = 16'h0A00+j, each sign-extended to 32 bits.
  - `done` asserts 121 cycles after `start`.
- Sign extension and junk upper bits:
  - `lsp_ele[5]` = 32'hDEAD_8123.
  - Required: memory at {freq_prev[10:6], 6'd5} = 32'hFFFF_8123. `lsp_ele` locations are unchanged.
- Iterated frames:
  - Run 4 consecutive updates with `lsp_ele` = frame number n (1..4) in all elements, restarting in the cycle after each `done`.
  - Required: row k = 4−k for all j.
  - Exactly 40 `writeEn` pulses per run; no writes outside the 0..39 offset window.
- Start during busy:
  - Pulse `start` again at cycles 10 and 120 of a run.
  - Required: single `done` at cycle 121, exactly 40 writes, no second run.
- Reset mid-run:
  - Drive `reset` = 0 at cycle 60.
  - Required: all outputs 0 within the same cycle, FSM in IDLE, no `done`.
  - A subsequent full run completes normally in 121 cycles.

Source files
------------

// File: rtl/lsp_prev_update.sv
// lsp_prev_update: shifts the four-row MA predictor history (freq_prev) in
// shared scratch memory down by one frame and writes the current lsp_ele
// vector into row 0. Each word takes a read, a latency wait and a write.
// All values are stored as sign-extended 16-bit Q13 words.
module lsp_prev_update #(
    parameter int M     = 10,
    parameter int MA_NP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] lspele,
    input  logic [10:0] freq_prev,
    input  logic [31:0] readIn,
    output logic [10:0] readAddr,
    output logic [10:0] writeAddr,
    output logic [31:0] writeOut,
    output logic        writeEn,
    output logic        done
);

    localparam logic [3:0] J_LAST  = 4'(M - 1);
    localparam logic [1:0] K_FIRST = 2'(MA_NP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  k, k_nxt;
    logic [3:0]  j, j_nxt;
    logic        ph, ph_nxt;     // 1 = copying lsp_ele into row 0
    logic [5:0]  src_off;
    logic [10:0] rd_addr_nxt;
    logic [10:0] wr_addr_nxt;

    // Only the high base bits are used for addressing and only the Q13 half
    // of the read word is kept.
    logic unused_bits;
    assign unused_bits = ^{readIn[31:16], lspele[3:0], freq_prev[5:0]};

    // Offset of history element [k][j]: 10k + j, built from shifts (max 39).
    function automatic logic [5:0] row_off(input logic [1:0] kk, input logic [3:0] jj);
        return {1'b0, kk, 3'b000} + {3'b000, kk, 1'b0} + {2'b00, jj};
    endfunction

    // Next-state and counter sequencing: descending rows, then the lsp_ele phase.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        j_nxt     = j;
        ph_nxt    = ph;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RD;
                    k_nxt     = K_FIRST;
                    j_nxt     = '0;
                    ph_nxt    = 1'b0;
                end
            end
            S_RD:   state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_WR;
            S_WR: begin
                if (ph && (j == J_LAST)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RD;
                    if (j == J_LAST) begin
                        j_nxt = '0;
                        if (k == 2'd1) begin
                            k_nxt  = '0;
                            ph_nxt = 1'b1;
                        end else begin
                            k_nxt = k - 2'd1;
                        end
                    end else begin
                        j_nxt = j + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                k_nxt     = '0;
                j_nxt     = '0;
                ph_nxt    = 1'b0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address generation: the read address uses the upcoming counters so it
    // can be registered on entry to RD; the write address uses the current ones.
    always_comb begin
        src_off     = row_off(k_nxt - 2'd1, j_nxt);
        rd_addr_nxt = ph_nxt ? {lspele[10:4], j_nxt} : {freq_prev[10:6], src_off};
        wr_addr_nxt = {freq_prev[10:6], row_off(k, j)};
    end

    // State, counters and registered memory-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            k         <= '0;
            j         <= '0;
            ph        <= 1'b0;
            readAddr  <= '0;
            writeAddr <= '0;
            writeOut  <= '0;
            writeEn   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            j       <= j_nxt;
            ph      <= ph_nxt;
            writeEn <= (state_nxt == S_WR);
            done    <= (state_nxt == S_DONE);
            if (state_nxt == S_RD) begin
                readAddr <= rd_addr_nxt;
            end
            if (state_nxt == S_WR) begin
                writeAddr <= wr_addr_nxt;
                writeOut  <= {{16{readIn[15]}}, readIn[15:0]};
            end
        end
    end

endmodule
